proc_ifetch: RTL and testbench
==============================

// Module: proc_ifetch
// PURPOSE
//  Instruction-fetch stage; sits directly downstream of proc_pc. Takes the current PC,
//  runs a req/ack transaction on a variable-latency instruction memory, and loads the
//  IF/ID pipeline register (instr, pc, pc+4) for decode. Drives pc_hold back to the PC
//  logic so the PC advances only when a fetch completes. Flushes on redirect.
// PARAMETERS
//  XLEN       32            address/data width
//  NOP_INSTR  32'h00000000  instruction word presented while if_valid=0 and at reset
// PORTS
//  clk         in   1     clock, all state updates on posedge
//  nrst        in   1     asynchronous active-low reset
//  pc_in       in   XLEN  current PC from proc_pc
//  redirect    in   1     branch/jump taken this cycle (same signal as pc_src); flush
//  pc_hold     out  1     1 = PC must not advance this cycle
//  imem_req    out  1     fetch request, held high until imem_ack
//  imem_addr   out  XLEN  fetch address, stable while imem_req=1
//  imem_ack    in   1     memory response valid this cycle (may be same cycle as req)
//  imem_rdata  in   XLEN  instruction word, valid when imem_ack=1
//  id_stall    in   1     decode cannot accept a new IF/ID word this cycle
//  if_valid    out  1     IF/ID register holds a live instruction
//  if_instr    out  XLEN  IF/ID instruction
//  if_pc       out  XLEN  IF/ID PC of that instruction
//  if_pc4      out  XLEN  if_pc + 4, wraps modulo 2^XLEN
//  if_misalign out  1     IF/ID PC had pc[1:0]!=0 (word still fetched, flag only)
// BEHAVIOUR
//  Reset (nrst=0, async): state=IDLE, imem_req=0, if_valid=0, if_instr=NOP_INSTR,
//   if_pc=if_pc4=0, if_misalign=0, skid empty, pc_hold=1. Reset mid-transaction drops it.
//  States: IDLE, FETCH, HOLD, DROP. IDLE lasts exactly 1 cycle after reset -> FETCH.
//  FETCH: imem_req=1. First request cycle: imem_addr=pc_in, copied into req_addr;
//   later cycles: imem_addr=req_addr. pc_hold=1 until the accepting ack.
//   ack & !redirect & (!if_valid | !id_stall): IF/ID <= {rdata, addr, addr+4},
//     if_valid=1, pc_hold=0 that cycle (PC advances), stay FETCH; next request
//     starts next cycle -> sustained 1 instr/cycle with zero-wait memory.
//   ack & !redirect & if_valid & id_stall: rdata/addr -> 1-entry skid, pc_hold=0
//     that cycle, -> HOLD.
//   ack & redirect: response discarded, stay FETCH, new request uses new pc_in.
//   !ack & redirect: -> DROP (request already outstanding, cannot be withdrawn).
//  HOLD: imem_req=0, pc_hold=1. When !id_stall: IF/ID <= skid, skid empty, -> FETCH.
//  DROP: imem_req=1 with req_addr held; on ack discard rdata -> FETCH. pc_hold=1.
//  Redirect (any state): if_valid<=0, if_instr<=NOP_INSTR, skid emptied at the edge;
//   redirect beats id_stall. HOLD+redirect -> FETCH.
//  IF/ID register holds value unchanged while if_valid & id_stall.
//  Never more than one outstanding imem transaction; no request in IDLE/HOLD.
//  Latency: ack in cycle N -> if_valid/if_instr visible after edge ending cycle N.
// TESTING
//  T1 reset then pc 0,4,8 with ack same cycle as req -> if_instr = mem[0],[4],[8]
//     on 3 consecutive cycles, pc_hold=0 each cycle, if_pc4 = 4,8,0xC.
//  T2 ack delayed 3 cycles at pc=0x10 -> imem_addr=0x10 held 4 cycles, pc_hold=1
//     for 3 cycles, then if_pc=0x10, if_valid=1.
//  T3 id_stall=1 for 4 cycles with if_valid=1, ack arrives -> skid filled, HOLD,
//     IF/ID unchanged; id_stall drops -> IF/ID = skid word, back to FETCH.
//  T4 redirect to 0x100 while req to 0x20 pending -> DROP, 0x20 data discarded,
//     if_valid=0, next req addr=0x100, first valid if_pc=0x100.
//  T5 pc=0xFFFFFFFC fetched -> if_pc4=0x00000000; pc=0x22 -> if_misalign=1.
//  T6 nrst low mid-FETCH (req pending) -> imem_req=0, if_valid=0, if_instr=NOP
//     immediately; after release 1 IDLE cycle then request at pc_in.

Source files
------------

// File: rtl/proc_ifetch.sv
// proc_ifetch: instruction-fetch stage between proc_pc and decode.
// Issues one req/ack fetch at a time to a variable-latency instruction memory,
// loads the IF/ID register {instr, pc, pc+4} and tells the PC logic via
// pc_hold when it may advance. A 1-entry skid catches a word that returns
// while decode is stalled. Redirect flushes IF/ID and the skid.
//
// Ports
//   clk, nrst              clock, asynchronous active-low reset
//   pc_in                  current PC from proc_pc
//   redirect               branch/jump taken this cycle (flush)
//   pc_hold                1 = PC must not advance this cycle
//   imem_req/addr          fetch request, address stable while req=1
//   imem_ack/rdata         memory response (ack may be in the request cycle)
//   id_stall               decode cannot accept a new IF/ID word
//   if_valid/instr/pc/pc4  IF/ID register contents
//   if_misalign            IF/ID PC was not word aligned
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | request outstanding to imem_addr
// HOLD  | fetched word parked in skid, waiting for decode
// DROP  | redirected while a request was outstanding, discard its response
module proc_ifetch #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = '0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            redirect,
  output logic            pc_hold,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic            if_misalign
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t          state, state_nxt;
  logic            req_first;   // FETCH cycle whose address has not been latched yet
  logic [XLEN-1:0] req_addr;
  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            ack_fetch;
  logic            accept;
  logic            to_skid;

  // First request cycle follows pc_in directly so a zero-wait memory can
  // sustain one instruction per cycle.
  assign imem_addr = req_first ? pc_in : req_addr;

  assign ack_fetch = (state == FETCH) && imem_ack && !redirect;
  assign accept    = ack_fetch && (!if_valid || !id_stall);
  assign to_skid   = ack_fetch && if_valid && id_stall;
  assign pc_hold   = !ack_fetch;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (imem_ack)      state_nxt = to_skid ? HOLD : FETCH;
        else if (redirect) state_nxt = DROP;
      end
      HOLD:  if (redirect || !id_stall) state_nxt = FETCH;
      DROP:  if (imem_ack) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      req_first   <= 1'b0;
      req_addr    <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= '0;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= '0;
      if_pc4      <= '0;
      if_misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      imem_req <= (state_nxt == FETCH) || (state_nxt == DROP);
      // A new address is taken whenever FETCH is entered afresh or the
      // previous request has just been answered.
      req_first <= (state_nxt == FETCH) && ((state != FETCH) || imem_ack);
      if (state == FETCH && !imem_ack)
        req_addr <= imem_addr;

      if (to_skid) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= imem_addr;
      end

      if (redirect) begin
        if_valid    <= 1'b0;
        if_instr    <= NOP_INSTR;
        if_misalign <= 1'b0;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        if_valid    <= 1'b1;
        if_instr    <= imem_rdata;
        if_pc       <= imem_addr;
        if_pc4      <= imem_addr + XLEN'(4);
        if_misalign <= |imem_addr[1:0];
      end else if (state == HOLD && !id_stall && skid_valid) begin
        if_valid    <= 1'b1;
        if_instr    <= skid_instr;
        if_pc       <= skid_pc;
        if_pc4      <= skid_pc + XLEN'(4);
        if_misalign <= |skid_pc[1:0];
        skid_valid  <= 1'b0;
      end else if (!id_stall) begin
        // decode consumed the word and nothing new arrived: bubble
        if_valid    <= 1'b0;
        if_instr    <= NOP_INSTR;
        if_misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_proc_ifetch.sv
module tb_proc_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        nrst;
  logic [31:0] pc_in;
  logic        redirect;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_misalign;

  int n_checks = 0;
  int n_err    = 0;

  proc_ifetch #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .nrst(nrst), .pc_in(pc_in), .redirect(redirect),
    .pc_hold(pc_hold), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_stall(id_stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc4(if_pc4), .if_misalign(if_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [31:0] t1_pc  [3];
  logic [31:0] t1_pc4 [3];

  initial begin
    t1_pc  = '{32'h0, 32'h4, 32'h8};
    t1_pc4 = '{32'h4, 32'h8, 32'hC};
    nrst = 1'b0; pc_in = '0; redirect = 1'b0; imem_ack = 1'b0;
    imem_rdata = '0; id_stall = 1'b0;

    // reset values
    mid();
    chk("rst_req",   imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc",    if_pc, 0);
    chk("rst_pc4",   if_pc4, 0);
    chk("rst_hold",  pc_hold, 1);
    tick();
    nrst = 1'b1;

    // IDLE cycle
    mid();
    chk("idle_req",  imem_req, 0);
    chk("idle_hold", pc_hold, 1);
    tick();

    // T1: zero-wait memory, 1 instr/cycle
    for (int i = 0; i < 3; i++) begin
      pc_in = t1_pc[i]; imem_ack = 1'b1; imem_rdata = mem(t1_pc[i]);
      mid();
      chk("t1_req",  imem_req, 1);
      chk("t1_addr", imem_addr, t1_pc[i]);
      chk("t1_hold", pc_hold, 0);
      tick();
      chk("t1_valid", if_valid, 1);
      chk("t1_instr", if_instr, mem(t1_pc[i]));
      chk("t1_pc4",   if_pc4, t1_pc4[i]);
    end

    // T2: ack three cycles late, address must stay at 0x10
    pc_in = 32'h10; imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t2_addr", imem_addr, 32'h10);
      chk("t2_hold", pc_hold, 1);
      chk("t2_req",  imem_req, 1);
      tick();
      pc_in = 32'hDEAD_0000;
    end
    imem_ack = 1'b1; imem_rdata = mem(32'h10);
    mid();
    chk("t2_addr_ack", imem_addr, 32'h10);
    chk("t2_hold_ack", pc_hold, 0);
    tick();
    chk("t2_valid", if_valid, 1);
    chk("t2_pc",    if_pc, 32'h10);

    // T3: decode stalled, word goes to skid
    pc_in = 32'h14; id_stall = 1'b1; imem_ack = 1'b1; imem_rdata = mem(32'h14);
    mid();
    chk("t3_hold_ack", pc_hold, 0);
    tick();
    pc_in = 32'h18; imem_ack = 1'b0; imem_rdata = '0;
    chk("t3_pc_kept", if_pc, 32'h10);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t3_req",  imem_req, 0);
      chk("t3_hold", pc_hold, 1);
      tick();
      chk("t3_pc_stall", if_pc, 32'h10);
      chk("t3_instr_stall", if_instr, mem(32'h10));
    end
    id_stall = 1'b0;
    mid();
    chk("t3_req_rel", imem_req, 0);
    tick();
    chk("t3_valid", if_valid, 1);
    chk("t3_pc",    if_pc, 32'h14);
    chk("t3_instr", if_instr, mem(32'h14));

    // T4: redirect while 0x20 outstanding (stall held so the flush is visible)
    pc_in = 32'h20; id_stall = 1'b1;
    mid();
    chk("t4_req", imem_req, 1);
    tick();
    chk("t4_valid_pre", if_valid, 1);
    redirect = 1'b1;
    mid();
    chk("t4_addr_redir", imem_addr, 32'h20);
    tick();
    redirect = 1'b0; id_stall = 1'b0; pc_in = 32'h100;
    chk("t4_valid_flush", if_valid, 0);
    chk("t4_instr_flush", if_instr, NOP);
    mid();
    chk("t4_drop_addr", imem_addr, 32'h20);
    chk("t4_drop_req",  imem_req, 1);
    chk("t4_drop_hold", pc_hold, 1);
    tick();
    imem_ack = 1'b1; imem_rdata = mem(32'h20);
    mid();
    chk("t4_drop_hold_ack", pc_hold, 1);
    tick();
    chk("t4_discard", if_valid, 0);
    imem_rdata = mem(32'h100);
    mid();
    chk("t4_new_addr", imem_addr, 32'h100);
    chk("t4_new_hold", pc_hold, 0);
    tick();
    chk("t4_new_valid", if_valid, 1);
    chk("t4_new_pc",    if_pc, 32'h100);

    // T5: pc+4 wrap and misalign flag
    pc_in = 32'hFFFF_FFFC; imem_rdata = mem(32'hFFFF_FFFC);
    tick();
    chk("t5_pc",    if_pc, 32'hFFFF_FFFC);
    chk("t5_pc4",   if_pc4, 32'h0);
    chk("t5_mis0",  if_misalign, 0);
    pc_in = 32'h22; imem_rdata = mem(32'h22);
    tick();
    chk("t5_mis1",  if_misalign, 1);
    chk("t5_pc4b",  if_pc4, 32'h26);

    // T6: async reset mid-FETCH
    pc_in = 32'h40; imem_ack = 1'b0; id_stall = 1'b1;
    mid();
    chk("t6_req_pre",   imem_req, 1);
    chk("t6_valid_pre", if_valid, 1);
    #1 nrst = 1'b0;
    #1;
    chk("t6_req_rst",   imem_req, 0);
    chk("t6_valid_rst", if_valid, 0);
    chk("t6_instr_rst", if_instr, NOP);
    chk("t6_hold_rst",  pc_hold, 1);
    tick();
    nrst = 1'b1; id_stall = 1'b0; pc_in = 32'h44;
    mid();
    chk("t6_idle_req", imem_req, 0);
    tick();
    imem_ack = 1'b1; imem_rdata = mem(32'h44);
    mid();
    chk("t6_req_post",  imem_req, 1);
    chk("t6_addr_post", imem_addr, 32'h44);
    tick();
    chk("t6_pc_post", if_pc, 32'h44);

    // ack in the same cycle as redirect: response discarded, stay in FETCH
    pc_in = 32'h48; redirect = 1'b1; imem_rdata = mem(32'h48);
    mid();
    chk("ar_hold", pc_hold, 1);
    tick();
    redirect = 1'b0; pc_in = 32'h200; imem_rdata = mem(32'h200);
    chk("ar_valid", if_valid, 0);
    chk("ar_req",   imem_req, 1);
    mid();
    chk("ar_addr", imem_addr, 32'h200);
    tick();
    chk("ar_pc",    if_pc, 32'h200);
    chk("ar_instr", if_instr, mem(32'h200));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
